// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the DMA burst scheduler.
package dma_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // A length field value n describes n + LEN_BEAT_OFFSET beats
  localparam int unsigned LEN_BEAT_OFFSET = 1;

  // Index width for an n-entry set; never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module dma_rr_pick
  import dma_sched_pkg::*;
#(
  parameter int unsigned CH_NUM = 4
) (
  input  logic [CH_NUM-1:0]        req,
  input  logic [idx_w(CH_NUM)-1:0] ptr,
  output logic [CH_NUM-1:0]        gnt_c,
  output logic [idx_w(CH_NUM)-1:0] idx_c,
  output logic                     vld_c
);

  localparam int unsigned IDX_W = idx_w(CH_NUM);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan channels starting at ptr; first hit wins
  always_comb begin
    gnt_c    = '0;
    idx_c    = '0;
    vld_c    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= CH_NUM) begin
        cand = cand - CH_NUM;
      end
      cand_idx = IDX_W'(cand);
      if (!vld_c && req[cand_idx]) begin
        vld_c           = 1'b1;
        idx_c           = cand_idx;
        gnt_c[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_burst_scheduler.sv
// Round-robin burst scheduler feeding one shared transfer engine, with beat watchdog.
module dma_burst_scheduler
  import dma_sched_pkg::*;
#(
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [CH_NUM-1:0]         ch_req_i,
  input  logic [CH_NUM*LEN_W-1:0]   ch_len_i,
  output logic [CH_NUM-1:0]         ch_ack_o,
  output logic [CH_NUM-1:0]         ch_done_o,
  output logic                      err_o,
  output logic                      eng_start_o,
  output logic [idx_w(CH_NUM)-1:0]  eng_ch_o,
  output logic [LEN_W-1:0]          eng_len_o,
  input  logic                      eng_beat_i,
  output logic                      busy_o
);

  localparam int unsigned IDX_W = idx_w(CH_NUM);
  localparam int unsigned WD_W  = idx_w(TIMEOUT);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  ch_q, ch_d;
  logic [CH_NUM-1:0] gnt_q, gnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_flag_q, err_flag_d;

  logic [CH_NUM-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [LEN_W-1:0]  pick_len;

  // Arbitration among pending channels
  dma_rr_pick #(
    .CH_NUM (CH_NUM)
  ) u_pick (
    .req   (ch_req_i),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .vld_c (pick_vld)
  );

  // Length field of the winning channel
  always_comb begin
    pick_len = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (pick_gnt[k]) begin
        pick_len = ch_len_i[k*LEN_W +: LEN_W];
      end
    end
  end

  // Next-state, beat counting and watchdog
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    gnt_d      = gnt_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    err_flag_d = err_flag_q;
    case (state_q)
      IDLE: begin
        if (enable_i && pick_vld) begin
          ch_d       = pick_idx;
          gnt_d      = pick_gnt;
          len_d      = pick_len;
          ptr_d      = (pick_idx == IDX_W'(CH_NUM - 1)) ? '0 : pick_idx + IDX_W'(1);
          err_flag_d = 1'b0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // Beats in this cycle are ignored; the engine only starts now
        cnt_d      = '0;
        wd_d       = '0;
        err_flag_d = 1'b0;
        state_d    = XFER;
      end
      XFER: begin
        if (eng_beat_i) begin
          wd_d = '0;
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered pulse outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ch_q        <= '0;
      gnt_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      err_flag_q  <= 1'b0;
      ch_ack_o    <= '0;
      ch_done_o   <= '0;
      err_o       <= 1'b0;
      eng_start_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      gnt_q       <= gnt_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      err_flag_q  <= err_flag_d;
      ch_ack_o    <= (state_d == GRANT) ? gnt_d : '0;
      ch_done_o   <= (state_d == DONE) ? gnt_d : '0;
      err_o       <= (state_d == DONE) && err_flag_d;
      eng_start_o <= (state_d == GRANT);
      busy_o      <= (state_d != IDLE);
    end
  end

  // Engine descriptor held from start to done
  assign eng_ch_o  = ch_q;
  assign eng_len_o = len_q;

endmodule
